// File: rtl/fp_pkg.sv
// Shared single-precision FP types and widths for the adder pipeline.
// Operands are unpacked here with exponent-zero values flushed to a zero mantissa.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;
   localparam int EXT_W = MAN_W + 4;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W:0]   mant;
   } fp_unpacked_t;

   typedef logic [EXT_W-1:0] fp_ext_mant_t;

   function automatic fp_unpacked_t unpackFp(input logic [EXP_W+MAN_W:0] raw);
      fp_unpacked_t u;
      u.sign = raw[EXP_W+MAN_W];
      u.exp  = raw[EXP_W+MAN_W-1:MAN_W];
      // No denormal support: exponent zero always means a zero mantissa.
      u.mant = (u.exp == '0) ? '0 : {1'b1, raw[MAN_W-1:0]};
      return u;
   endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right shift of the extended smaller mantissa; shifted-out ones fold into the sticky LSB.
// Shifts of SAT_SH or more leave only the sticky bit.
module fp_align_shifter
   import fp_pkg::*;
#(
   parameter int SAT_SH = 26
) (
   input  fp_ext_mant_t     inVal,
   input  logic [EXP_W-1:0] shiftAmt,
   output fp_ext_mant_t     outVal
);

   localparam logic [EXP_W-1:0] SAT_LIM = EXP_W'(SAT_SH);

   fp_ext_mant_t lostMask;

   always_comb begin
      // NOTE: every output gets a default first so this block can never infer a latch.
      outVal   = '0;
      lostMask = '0;
      if (shiftAmt >= SAT_LIM) begin
         outVal[0] = |inVal;
      end else begin
         lostMask  = ~({EXT_W{1'b1}} << shiftAmt);
         outVal    = inVal >> shiftAmt;
         outVal[0] = outVal[0] | (|(inVal & lostMask));
      end
   end

endmodule

// File: rtl/fp_align_add.sv
// FP adder front end: stage 1 unpacks, swaps and aligns; stage 2 adds or subtracts.
// Produces an unnormalized magnitude with G/R/S for the downstream normalize/round stage.
module fp_align_add
   import fp_pkg::*;
#(
   parameter int SAT_SH = 26
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] op_a,
   input  logic [EXP_W+MAN_W:0] op_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [MAN_W:0]       aligned_result,
   output logic                 guard_bit,
   output logic                 round_bit,
   output logic                 sticky_bit,
   output logic [EXP_W-1:0]     exponent_out,
   output logic                 aligned_sign,
   output logic                 exp_overflow
);

   fp_unpacked_t     unpA, unpB;
   logic             aIsL, signL;
   logic [MAN_W:0]   mantL, mantS;
   logic [EXP_W-1:0] expL, expS, expDiff;
   fp_ext_mant_t     alignedS;

   logic             s1Valid, s1Sign, s1EffSub, s2Load;
   fp_ext_mant_t     s1L, s1S;
   logic [EXP_W-1:0] s1Exp;

   assign unpA    = unpackFp(op_a);
   assign unpB    = unpackFp(op_b);
   assign aIsL    = {unpA.exp, unpA.mant} >= {unpB.exp, unpB.mant};
   assign mantL   = aIsL ? unpA.mant : unpB.mant;
   assign mantS   = aIsL ? unpB.mant : unpA.mant;
   assign expL    = aIsL ? unpA.exp  : unpB.exp;
   assign expS    = aIsL ? unpB.exp  : unpA.exp;
   assign signL   = aIsL ? unpA.sign : unpB.sign;
   assign expDiff = expL - expS;

   fp_align_shifter #(.SAT_SH(SAT_SH)) uShift (
      .inVal    ({mantS, 3'b000}),
      .shiftAmt (expDiff),
      .outVal   (alignedS)
   );

   assign s2Load   = !out_valid || out_ready;
   assign in_ready = !s1Valid || s2Load;

   always_ff @(posedge clk) begin
      // NOTE: state uses <= so both stages see pre-edge values and shift together.
      if (reset) begin
         s1Valid  <= 1'b0;
         s1L      <= '0;
         s1S      <= '0;
         s1Exp    <= '0;
         s1Sign   <= 1'b0;
         s1EffSub <= 1'b0;
      end else if (in_ready) begin
         s1Valid <= in_valid;
         if (in_valid) begin
            s1L      <= {mantL, 3'b000};
            s1S      <= alignedS;
            s1Exp    <= expL;
            s1Sign   <= signL;
            s1EffSub <= unpA.sign ^ unpB.sign;
         end
      end
   end

   logic [EXT_W:0]   sumFull;
   fp_ext_mant_t     diff;
   logic [EXP_W:0]   expInc;
   logic [MAN_W:0]   nxtResult;
   logic [2:0]       nxtGrs;
   logic [EXP_W-1:0] nxtExp;
   logic             nxtSign, nxtOvf;

   assign sumFull = {1'b0, s1L} + {1'b0, s1S};
   assign diff    = s1L - s1S;
   assign expInc  = {1'b0, s1Exp} + 1'b1;

   // Exact-zero subtracts report +0; both-zero inputs fall out of the same rules.
   always_comb begin
      nxtResult = diff[EXT_W-1:3];
      nxtGrs    = diff[2:0];
      nxtExp    = s1Exp;
      nxtSign   = s1Sign;
      nxtOvf    = 1'b0;
      if (s1EffSub) begin
         if (diff == '0) begin
            nxtSign = 1'b0;
            nxtExp  = '0;
         end
      end else if (sumFull[EXT_W]) begin
         nxtResult = sumFull[EXT_W:4];
         nxtGrs    = {sumFull[3], sumFull[2], sumFull[1] | sumFull[0]};
         if (expInc >= {1'b0, {EXP_W{1'b1}}}) begin
            nxtOvf = 1'b1;
            nxtExp = '1;
         end else begin
            nxtExp = expInc[EXP_W-1:0];
         end
      end else begin
         nxtResult = sumFull[EXT_W-1:3];
         nxtGrs    = sumFull[2:0];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: result registers are cleared as well, so the outputs read 0 after reset.
      if (reset) begin
         out_valid      <= 1'b0;
         aligned_result <= '0;
         guard_bit      <= 1'b0;
         round_bit      <= 1'b0;
         sticky_bit     <= 1'b0;
         exponent_out   <= '0;
         aligned_sign   <= 1'b0;
         exp_overflow   <= 1'b0;
      end else if (s2Load) begin
         out_valid <= s1Valid;
         if (s1Valid) begin
            aligned_result <= nxtResult;
            {guard_bit, round_bit, sticky_bit} <= nxtGrs;
            exponent_out   <= nxtExp;
            aligned_sign   <= nxtSign;
            exp_overflow   <= nxtOvf;
         end
      end
   end

endmodule
